// File: rtl/arty_dma_arbiter.sv
// Two-requester DMA arbiter. Packets and write beats go to one DRAM controller.
// Read beats are routed back to the issuing requester using a tag FIFO.
// Latency: a packet is offered one cycle after a request is seen (IDLE->PKT).
//   Write and read beats pass through combinationally.
// Backpressure: controller yumi passes straight to the granted requester.
//   Read packets stall while the tag FIFO is full.
//   Read return follows the target requester's ready.
//
// Ports: clk_i / reset_active_low_i (async, active-low);
//        req_pkt_*, req_wdata_*  : per-requester packet and write-data channels (yumi style)
//        req_rdata_*             : per-requester read return (valid/ready)
//        dma_pkt_*, dma_data_o/v_o/yumi_i : packet and write data to the controller
//        dma_data_i/v_i/ready_and_o       : read data from the controller
//        error_o                 : sticky flag, read data arrived with no read outstanding
// Optional: define ARTY_DMA_ARB_RR_EN for round-robin arbitration.
//   The default is fixed priority, with requester 0 winning.

// Small generic FIFO used for the outstanding-read tag queue.
// Latency: push visible at head the cycle after; pop takes effect at the clock edge.
// Backpressure: caller must not push when full_o or pop when empty_o.
module arty_dma_arbiter_fifo #(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               push_i,
    input  logic [width_p-1:0] dat_i,
    input  logic               pop_i,
    output logic [width_p-1:0] dat_o,
    output logic               empty_o,
    output logic               full_o
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [els_p-1:0][width_p-1:0] mem_q;
    logic [ptr_w_lp-1:0]           wr_q, rd_q;
    logic [cnt_w_lp-1:0]           cnt_q;

    // Pointers wrap explicitly so that non-power-of-two depths work.
    function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= ptr_next(wr_q);
            if (pop_i)  rd_q <= ptr_next(rd_q);
            cnt_q <= cnt_q + cnt_w_lp'(push_i) - cnt_w_lp'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= dat_i;
    end

    assign dat_o   = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == cnt_w_lp'(els_p));
endmodule

module arty_dma_arbiter #(
    parameter int pkt_width_p  = 29,
    parameter int data_width_p = 64,
    parameter int beats_p      = 8,
    parameter int tag_els_p    = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_active_low_i,
    input  logic [1:0][pkt_width_p-1:0]  req_pkt_i,
    input  logic [1:0]                   req_pkt_v_i,
    output logic [1:0]                   req_pkt_yumi_o,
    input  logic [1:0][data_width_p-1:0] req_wdata_i,
    input  logic [1:0]                   req_wdata_v_i,
    output logic [1:0]                   req_wdata_yumi_o,
    output logic [1:0][data_width_p-1:0] req_rdata_o,
    output logic [1:0]                   req_rdata_v_o,
    input  logic [1:0]                   req_rdata_ready_and_i,
    output logic [pkt_width_p-1:0]       dma_pkt_o,
    output logic                         dma_pkt_v_o,
    input  logic                         dma_pkt_yumi_i,
    output logic [data_width_p-1:0]      dma_data_o,
    output logic                         dma_data_v_o,
    input  logic                         dma_data_yumi_i,
    input  logic [data_width_p-1:0]      dma_data_i,
    input  logic                         dma_data_v_i,
    output logic                         dma_data_ready_and_o,
    output logic                         error_o
);
    localparam int beat_w_lp = (beats_p > 1) ? $clog2(beats_p) : 1;
    localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(beats_p - 1);

    typedef enum logic [1:0] {IDLE_S, PKT_S, WDATA_S} state_e;

    state_e               state_q, state_d;
    logic                 grant_q, grant_d;
    logic [beat_w_lp-1:0] wbeat_q, wbeat_d;
    logic [beat_w_lp-1:0] rbeat_q, rbeat_d;
    logic                 error_q, error_d;
    logic                 winner;
    logic                 pkt_is_read;
    logic                 tag_push, tag_pop, tag_head, tag_empty, tag_full;
`ifdef ARTY_DMA_ARB_RR_EN
    // Holds the requester that has priority at the next contention.
    logic                 rr_q, rr_d;
`endif

    // MSB of a packet is write_not_read.
    assign pkt_is_read = ~req_pkt_i[grant_q][pkt_width_p-1];

    always_comb begin
`ifdef ARTY_DMA_ARB_RR_EN
        winner = req_pkt_v_i[rr_q] ? rr_q : ~rr_q;
`else
        winner = ~req_pkt_v_i[0];
`endif
    end

    // Request path: IDLE arbitrates, PKT forwards the packet, WDATA forwards write beats.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        wbeat_d          = wbeat_q;
        tag_push         = 1'b0;
        dma_pkt_o        = '0;
        dma_pkt_v_o      = 1'b0;
        req_pkt_yumi_o   = '0;
        dma_data_o       = '0;
        dma_data_v_o     = 1'b0;
        req_wdata_yumi_o = '0;
`ifdef ARTY_DMA_ARB_RR_EN
        rr_d             = rr_q;
`endif
        case (state_q)
            IDLE_S: begin
                if (|req_pkt_v_i) begin
                    grant_d = winner;
                    state_d = PKT_S;
                end
            end
            PKT_S: begin
                dma_pkt_o               = req_pkt_i[grant_q];
                // A read cannot be issued without a free tag slot for its return.
                dma_pkt_v_o             = req_pkt_v_i[grant_q] & ~(pkt_is_read & tag_full);
                req_pkt_yumi_o[grant_q] = dma_pkt_yumi_i;
                if (dma_pkt_v_o && dma_pkt_yumi_i) begin
`ifdef ARTY_DMA_ARB_RR_EN
                    rr_d = ~grant_q;
`endif
                    if (pkt_is_read) begin
                        tag_push = 1'b1;
                        state_d  = IDLE_S;
                    end else begin
                        wbeat_d  = '0;
                        state_d  = WDATA_S;
                    end
                end
            end
            WDATA_S: begin
                dma_data_o                = req_wdata_i[grant_q];
                dma_data_v_o              = req_wdata_v_i[grant_q];
                req_wdata_yumi_o[grant_q] = dma_data_yumi_i;
                if (dma_data_v_o && dma_data_yumi_i) begin
                    if (wbeat_q == last_beat_lp) begin
                        wbeat_d = '0;
                        state_d = IDLE_S;
                    end else begin
                        wbeat_d = wbeat_q + beat_w_lp'(1);
                    end
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    // Read return path runs regardless of the request-path state.
    always_comb begin
        req_rdata_o          = '0;
        req_rdata_v_o        = '0;
        dma_data_ready_and_o = 1'b0;
        rbeat_d              = rbeat_q;
        tag_pop              = 1'b0;
        if (!tag_empty) begin
            req_rdata_o[tag_head]   = dma_data_i;
            req_rdata_v_o[tag_head] = dma_data_v_i;
            dma_data_ready_and_o    = req_rdata_ready_and_i[tag_head];
            if (dma_data_v_i && dma_data_ready_and_o) begin
                if (rbeat_q == last_beat_lp) begin
                    rbeat_d = '0;
                    tag_pop = 1'b1;
                end else begin
                    rbeat_d = rbeat_q + beat_w_lp'(1);
                end
            end
        end
        error_d = error_q | (tag_empty & dma_data_v_i);
    end

    always_ff @(posedge clk_i or negedge reset_active_low_i) begin
        if (!reset_active_low_i) begin
            state_q <= IDLE_S;
            grant_q <= 1'b0;
            wbeat_q <= '0;
            rbeat_q <= '0;
            error_q <= 1'b0;
`ifdef ARTY_DMA_ARB_RR_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            wbeat_q <= wbeat_d;
            rbeat_q <= rbeat_d;
            error_q <= error_d;
`ifdef ARTY_DMA_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    arty_dma_arbiter_fifo #(
        .width_p (1),
        .els_p   (tag_els_p)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_n_i (reset_active_low_i),
        .push_i  (tag_push),
        .dat_i   (grant_q),
        .pop_i   (tag_pop),
        .dat_o   (tag_head),
        .empty_o (tag_empty),
        .full_o  (tag_full)
    );

    assign error_o = error_q;
endmodule

// File: tb/tb_arty_dma_arbiter.sv
// Self-checking bench for arty_dma_arbiter.
// Latency: reference model is an in-order scoreboard; the controller model returns reads as queued.
// Backpressure: controller model yumis immediately or every other cycle; read return can be paused.
module tb_arty_dma_arbiter;
    localparam int PW    = 29;
    localparam int DW    = 64;
    localparam int BEATS = 8;
    localparam int NV    = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0][PW-1:0] req_pkt_i;
    logic [1:0]         req_pkt_v_i, req_pkt_yumi_o;
    logic [1:0][DW-1:0] req_wdata_i;
    logic [1:0]         req_wdata_v_i, req_wdata_yumi_o;
    logic [1:0][DW-1:0] req_rdata_o;
    logic [1:0]         req_rdata_v_o, req_rdata_ready_and_i;
    logic [PW-1:0]      dma_pkt_o;
    logic               dma_pkt_v_o, dma_pkt_yumi_i;
    logic [DW-1:0]      dma_data_o;
    logic               dma_data_v_o, dma_data_yumi_i;
    logic [DW-1:0]      dma_data_i;
    logic               dma_data_v_i, dma_data_ready_and_o;
    logic               error_o;

    arty_dma_arbiter dut (
        .clk_i                 (clk),
        .reset_active_low_i    (rst_n),
        .req_pkt_i             (req_pkt_i),
        .req_pkt_v_i           (req_pkt_v_i),
        .req_pkt_yumi_o        (req_pkt_yumi_o),
        .req_wdata_i           (req_wdata_i),
        .req_wdata_v_i         (req_wdata_v_i),
        .req_wdata_yumi_o      (req_wdata_yumi_o),
        .req_rdata_o           (req_rdata_o),
        .req_rdata_v_o         (req_rdata_v_o),
        .req_rdata_ready_and_i (req_rdata_ready_and_i),
        .dma_pkt_o             (dma_pkt_o),
        .dma_pkt_v_o           (dma_pkt_v_o),
        .dma_pkt_yumi_i        (dma_pkt_yumi_i),
        .dma_data_o            (dma_data_o),
        .dma_data_v_o          (dma_data_v_o),
        .dma_data_yumi_i       (dma_data_yumi_i),
        .dma_data_i            (dma_data_i),
        .dma_data_v_i          (dma_data_v_i),
        .dma_data_ready_and_o  (dma_data_ready_and_o),
        .error_o               (error_o)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    typedef struct {
        int          r;
        logic [PW-1:0] pkt;
    } pkt_exp_t;
    typedef struct {
        int          r;
        logic [DW-1:0] d;
    } rd_exp_t;

    pkt_exp_t      pkt_q[$];
    logic [DW-1:0] wd_q[$];
    rd_exp_t       rd_q[$];
    pkt_exp_t      pe;
    rd_exp_t       re;
    logic [DW-1:0] we;

    // ---------------- controller model ----------------
    bit            pkt_yumi_en = 1'b1;
    bit            wy_en       = 1'b1;
    bit            wy_alt      = 1'b0;
    bit            wy_phase    = 1'b0;
    bit            ret_en      = 1'b1;
    bit            force_v     = 1'b0;
    bit            ret_v       = 1'b0;
    bit            ret_fire    = 1'b0;
    bit            sb_w_en     = 1'b1;
    logic [DW-1:0] ret_dat     = '0;
    logic [27:0]   ret_q[$];
    int            ret_beat    = 0;
    int            wbeats_seen = 0;
    int            rbeats_seen = 0;

    assign dma_pkt_yumi_i  = pkt_yumi_en & dma_pkt_v_o;
    assign dma_data_yumi_i = wy_en & dma_data_v_o & (wy_alt ? wy_phase : 1'b1);
    assign dma_data_v_i    = ret_v | force_v;
    assign dma_data_i      = ret_dat;

    always begin
        @(posedge clk); #1;
        wy_phase = ~wy_phase;
    end

    // Returns 8 beats per accepted read, data = address<<8 | beat.
    always begin
        @(posedge clk); #1;
        if (!rst_n) begin
            ret_q.delete();
            ret_beat = 0;
            ret_v    = 1'b0;
        end else begin
            if (ret_fire) begin
                ret_beat++;
                if (ret_beat == BEATS) begin
                    ret_beat = 0;
                    void'(ret_q.pop_front());
                end
            end
            if (ret_en && ret_q.size() > 0) begin
                ret_v   = 1'b1;
                ret_dat = (64'(ret_q[0]) << 8) | 64'(ret_beat);
            end else begin
                ret_v   = 1'b0;
            end
        end
    end

    // ---------------- monitors (sampled on the falling edge) ----------------
    always @(negedge clk) begin
        ret_fire = ret_v && dma_data_ready_and_o;
        if (rst_n && dma_pkt_v_o && dma_pkt_yumi_i) begin
            if (pkt_q.size() == 0) begin
                chk("pkt_unexpected", 64'(pkt_q.size()), 64'd1);
            end else begin
                pe = pkt_q.pop_front();
                chk("pkt", 64'(dma_pkt_o), 64'(pe.pkt));
                chk("pkt_yumi", 64'(req_pkt_yumi_o), (pe.r == 1) ? 64'd2 : 64'd1);
            end
            if (!dma_pkt_o[PW-1]) ret_q.push_back(dma_pkt_o[27:0]);
        end
        if (rst_n && dma_data_v_o && dma_data_yumi_i) begin
            wbeats_seen++;
            if (sb_w_en) begin
                if (wd_q.size() == 0) begin
                    chk("wdata_unexpected", 64'(wd_q.size()), 64'd1);
                end else begin
                    we = wd_q.pop_front();
                    chk("wdata", dma_data_o, we);
                end
            end
        end
        for (int r = 0; r < 2; r++) begin
            if (rst_n && req_rdata_v_o[r] && req_rdata_ready_and_i[r]) begin
                rbeats_seen++;
                if (rd_q.size() == 0) begin
                    chk("rdata_unexpected", 64'(rd_q.size()), 64'd1);
                end else begin
                    re = rd_q.pop_front();
                    chk("rdata_dst", 64'(r), 64'(re.r));
                    chk("rdata", req_rdata_o[r], re.d);
                    chk("rdata_other_v", 64'(req_rdata_v_o[1-r]), 64'd0);
                    chk("rdata_other_dat", req_rdata_o[1-r], 64'd0);
                end
            end
        end
    end

    // ---------------- requester drivers ----------------
    task automatic send_pkt(input int r, input logic [PW-1:0] pkt, output int lat);
        req_pkt_i[r]   = pkt;
        req_pkt_v_i[r] = 1'b1;
        lat = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (req_pkt_yumi_o[r]) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat == 0) chk("pkt_timeout", 64'(lat), 64'd1);
        @(posedge clk); #1;
        req_pkt_v_i[r] = 1'b0;
    endtask

    task automatic send_wdata(input int r, input logic [DW-1:0] base);
        bit got;
        for (int i = 0; i < BEATS; i++) begin
            req_wdata_i[r]   = base + 64'(i);
            req_wdata_v_i[r] = 1'b1;
            wd_q.push_back(base + 64'(i));
            got = 1'b0;
            for (int c = 0; c < 50 && !got; c++) begin
                @(negedge clk);
                got = req_wdata_yumi_o[r];
                @(posedge clk); #1;
            end
            if (!got) chk("wdata_timeout", 64'(got), 64'd1);
        end
        // Burst complete: further write data must be ignored.
        req_wdata_i[r] = 64'hBAD0;
        @(negedge clk);
        chk("wdata_done_v", 64'(dma_data_v_o), 64'd0);
        chk("wdata_done_yumi", 64'(req_wdata_yumi_o), 64'd0);
        @(posedge clk); #1;
        req_wdata_v_i[r] = 1'b0;
    endtask

    task automatic push_read_exp(input int r, input logic [27:0] addr);
        pkt_q.push_back('{r, {1'b0, addr}});
        for (int i = 0; i < BEATS; i++) rd_q.push_back('{r, (64'(addr) << 8) | 64'(i)});
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 2000 && rd_q.size() > 0; c++) begin
            @(posedge clk); #1;
        end
        chk("drain", 64'(rd_q.size()), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int            r;
        bit            wr;
        logic [27:0]   addr;
        logic [DW-1:0] base;
        bit            alt;
        logic [PW-1:0] exp_pkt;
        int            exp_lat;
    } vec_t;
    vec_t vecs[NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat, lat0, lat1, held, base_cnt, n0, n1, rsel;
        bit  got, rr_mode;
        logic [27:0] a;
`ifdef ARTY_DMA_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        vecs[0] = '{0, 1'b0, 28'h0000100, 64'h0,                   1'b0, 29'h00000100, 2};
        vecs[1] = '{1, 1'b1, 28'h0000200, 64'h0,                   1'b1, 29'h10000200, 2};
        vecs[2] = '{1, 1'b0, 28'h0ABCDEF, 64'h0,                   1'b0, 29'h00ABCDEF, 2};
        vecs[3] = '{0, 1'b1, 28'hFFFFFFF, 64'hDEAD_0000_0000_0000, 1'b0, 29'h1FFFFFFF, 2};
        vecs[4] = '{0, 1'b0, 28'hFFFFFFF, 64'h0,                   1'b0, 29'h0FFFFFFF, 2};

        req_pkt_i = '0; req_pkt_v_i = '0; req_wdata_i = '0; req_wdata_v_i = '0;
        req_rdata_ready_and_i = 2'b11;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset: outputs stay quiet even with every input asserted.
        req_pkt_v_i = 2'b11; req_wdata_v_i = 2'b11; force_v = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pkt_v", 64'(dma_pkt_v_o), 64'd0);
        chk("rst_pkt_yumi", 64'(req_pkt_yumi_o), 64'd0);
        chk("rst_wdata_yumi", 64'(req_wdata_yumi_o), 64'd0);
        chk("rst_data_v", 64'(dma_data_v_o), 64'd0);
        chk("rst_rdata_v", 64'(req_rdata_v_o), 64'd0);
        chk("rst_ready", 64'(dma_data_ready_and_o), 64'd0);
        chk("rst_error", 64'(error_o), 64'd0);
        req_pkt_v_i = '0; req_wdata_v_i = '0; force_v = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven single-requester transactions.
        for (int v = 0; v < NV; v++) begin
            pkt_q.push_back('{vecs[v].r, vecs[v].exp_pkt});
            if (!vecs[v].wr)
                for (int i = 0; i < BEATS; i++)
                    rd_q.push_back('{vecs[v].r, (64'(vecs[v].addr) << 8) | 64'(i)});
            wy_alt = vecs[v].alt;
            send_pkt(vecs[v].r, {vecs[v].wr, vecs[v].addr}, lat);
            chk("pkt_latency", 64'(lat), 64'(vecs[v].exp_lat));
            if (vecs[v].wr) begin
                send_wdata(vecs[v].r, vecs[v].base);
            end else begin
                wait_drain();
                chk("fifo_empty_after_read", 64'(dma_data_ready_and_o), 64'd0);
            end
        end
        wy_alt = 1'b0;

        // Contention: both requesters issue four reads back to back.
        n0 = 0; n1 = 0;
        for (int k = 0; k < 8; k++) begin
            rsel = rr_mode ? (k % 2) : ((k < 4) ? 0 : 1);
            if (rsel == 0) begin a = 28'h300 + 28'(n0); n0++; end
            else           begin a = 28'h310 + 28'(n1); n1++; end
            push_read_exp(rsel, a);
        end
        fork
            begin
                for (int n = 0; n < 4; n++) send_pkt(0, {1'b0, 28'h300 + 28'(n)}, lat0);
            end
            begin
                for (int n = 0; n < 4; n++) send_pkt(1, {1'b0, 28'h310 + 28'(n)}, lat1);
            end
        join
        wait_drain();

        // Tag FIFO full: fifth read is held until the first return completes.
        ret_en = 1'b0;
        for (int n = 0; n < 4; n++) begin
            push_read_exp(0, 28'h400 + 28'(n));
            send_pkt(0, {1'b0, 28'h400 + 28'(n)}, lat);
        end
        push_read_exp(0, 28'h404);
        req_pkt_i[0] = {1'b0, 28'h404};
        req_pkt_v_i[0] = 1'b1;
        held = 0;
        repeat (20) begin
            @(negedge clk);
            if (dma_pkt_v_o) held++;
            @(posedge clk); #1;
        end
        chk("full_pkt_held", 64'(held), 64'd0);
        base_cnt = rbeats_seen;
        ret_en = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (req_pkt_yumi_o[0]) got = 1'b1;
            @(posedge clk); #1;
        end
        chk("full_release", 64'(got), 64'd1);
        chk("full_release_after_8", 64'((rbeats_seen - base_cnt) >= BEATS), 64'd1);
        req_pkt_v_i[0] = 1'b0;
        wait_drain();

        // Unexpected read data with no read outstanding.
        force_v = 1'b1;
        @(negedge clk);
        chk("err_ready", 64'(dma_data_ready_and_o), 64'd0);
        chk("err_rdata_v", 64'(req_rdata_v_o), 64'd0);
        chk("err_not_yet", 64'(error_o), 64'd0);
        @(posedge clk); #1;
        force_v = 1'b0;
        chk("err_set", 64'(error_o), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 64'(error_o), 64'd1);

        // Reset during write beat 3 abandons the burst.
        sb_w_en = 1'b0;
        pkt_q.push_back('{1, {1'b1, 28'h500}});
        send_pkt(1, {1'b1, 28'h500}, lat);
        req_wdata_i[1] = 64'h55;
        req_wdata_v_i[1] = 1'b1;
        base_cnt = wbeats_seen;
        for (int c = 0; c < 50 && (wbeats_seen - base_cnt) < 3; c++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_beats", 64'(wbeats_seen - base_cnt), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_data_v", 64'(dma_data_v_o), 64'd0);
        chk("rst_mid_wyumi", 64'(req_wdata_yumi_o), 64'd0);
        chk("rst_mid_pkt_v", 64'(dma_pkt_v_o), 64'd0);
        chk("rst_mid_error", 64'(error_o), 64'd0);
        chk("rst_mid_ready", 64'(dma_data_ready_and_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_data_v", 64'(dma_data_v_o), 64'd0);
        @(posedge clk); #1;
        req_wdata_v_i[1] = 1'b0;
        sb_w_en = 1'b1;

        // Recovery after reset.
        push_read_exp(0, 28'h600);
        send_pkt(0, {1'b0, 28'h600}, lat);
        chk("recover_latency", 64'(lat), 64'd2);
        wait_drain();

        repeat (4) @(posedge clk);
        #1;
        chk("pkt_q_empty", 64'(pkt_q.size()), 64'd0);
        chk("wd_q_empty", 64'(wd_q.size()), 64'd0);
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
